difftest_commit_packer: RTL
===========================

Name: difftest_commit_packer

Overview:
- Synthesizable producer side of the difftest instruction-commit interface.
- Takes up to COMMIT_WIDTH commit lanes per cycle from the ROB commit stage and buffers them in a FIFO.
- Emits one commit record per cycle over a valid/ready stream toward the difftest transport or DPI sink.
- Compacts sparse lanes, preserves program order, and counts events dropped on overflow, because commit can never stall.

Parameters:
- COMMIT_WIDTH, 2, number of commit lanes sampled per cycle (1..4).
- DEPTH, 8, FIFO entries; power of 2, >= COMMIT_WIDTH.
- CORE_ID, 0, 8-bit value driven on io_out_coreid.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  global difftest enable; 0 = lanes ignored, nothing enqueued.
- io_in_valid  in  COMMIT_WIDTH  per-lane commit valid.
- io_in_pc  in  64*COMMIT_WIDTH  lane i at bits [64i+63:64i].
- io_in_instr  in  32*COMMIT_WIDTH  instruction word per lane.
- io_in_robIdx  in  10*COMMIT_WIDTH  ROB index per lane.
- io_in_wdest  in  8*COMMIT_WIDTH  destination register per lane.
- io_in_flags  in  4*COMMIT_WIDTH  per lane {skip,isRVC,rfwen,fpwen}, with skip at the MSB.
- io_out_valid  out  1  record available.
- io_out_ready  in  1  consumer accepts record this cycle.
- io_out_pc  out  64, io_out_instr  out  32, io_out_robIdx  out  10, io_out_wdest  out  8, io_out_flags  out  4  head record fields.
- io_out_index  out  8  original lane number of the head record.
- io_out_coreid  out  8  constant CORE_ID.
- io_overflow  out  1  sticky; set on any dropped group.
- io_drop_cnt  out  16  saturating count of dropped lane records.

Behaviour:
- Reset (sync): FIFO empty, rd/wr pointers 0, count 0.
  - Outputs after reset: io_out_valid 0, io_overflow 0, io_drop_cnt 0.
  - Data outputs after reset are 0, because all entries are cleared.
- Reset wins over all same-cycle enqueue and dequeue activity.
- Enqueue condition, evaluated each cycle with enable=1:
  - n = popcount(io_in_valid).
  - free = DEPTH - count, using registered count only; a same-cycle dequeue is not credited.
- Fit (n <= free):
  - Valid lanes are written in ascending lane order into consecutive entries starting at wr_ptr.
  - Each entry stores its lane number in the index field.
  - wr_ptr advances by n, modulo DEPTH.
- No fit (n > free):
  - The whole group is dropped (all-or-nothing, no partial write).
  - io_overflow is set to 1.
  - io_drop_cnt += n, saturating at 0xFFFF.
- n = 0 or enable = 0: no write.
- Dequeue: when io_out_valid && io_out_ready, rd_ptr advances by 1 modulo DEPTH.
- count(next) = count + written - dequeued. Simultaneous enqueue and dequeue are both applied.
- Output:
  - io_out_valid = (count != 0).
  - io_out_* = entry[rd_ptr], with no combinational path from io_in_*.
  - Latency: a lane valid in cycle N appears at the output no earlier than cycle N+1.
- Stream rule: while io_out_valid=1 and io_out_ready=0, all io_out_* fields hold stable.
- Pointer width is log2(DEPTH); count width is log2(DEPTH)+1. Wrap-around is implicit in pointer width.
- io_overflow clears only on reset.

Optional Feature:
- Macro: DIFFTEST_COMMIT_SEQ_EN.
- Defined:
  - Adds output port io_out_seq (out, 32).
  - A 32-bit sequence counter resets to 0 and increments by 1 per enqueued record, wrapping at 2^32.
  - Dropped records do not consume sequence numbers.
  - Each entry stores its sequence number, which is presented on io_out_seq with the record.
- Undefined:
  - No port, no counter, no storage.
  - Behaviour is otherwise identical.

Test Plan:
- Ordering: reset, then cycle 1 io_in_valid=2'b10 with pc1=0x80000004, io_out_ready=1 -> cycle 2 io_out_valid=1, io_out_pc=0x80000004, io_out_index=1; cycle 3 io_out_valid=0.
- Compaction: both lanes valid, pc0=0x1000, pc1=0x1004 -> two records in order: 0x1000 (index 0), then 0x1004 (index 1).
- Overflow: io_out_ready=0, fill 8 entries with 4 cycles of 2 lanes, then one more 2-lane cycle -> count stays 8, io_overflow=1, io_drop_cnt=2. Then drain -> 8 records in original order.
- Partial fit dropped:
  - 7 entries held, 2-lane group arrives -> dropped: count 7, io_drop_cnt +2.
  - 1-lane group next cycle -> accepted, count 8.
- Wrap and simultaneous: ready toggled randomly over 100 cycles with enqueue and dequeue in the same cycle at count=DEPTH -> the dequeue is not credited, the group is dropped, and ordering holds across pointer wrap. With DIFFTEST_COMMIT_SEQ_EN, io_out_seq is strictly consecutive.
- Enable/reset: enable=0 with valid lanes -> no records. Reset asserted while 5 records are queued -> next cycle io_out_valid=0 and io_drop_cnt=0.

Source files
------------

// File: rtl/difftest_commit_packer.sv
// Difftest commit packer: compacts up to COMMIT_WIDTH commit lanes per cycle into a FIFO and
// streams one record per cycle. Define DIFFTEST_COMMIT_SEQ_EN to add per-record sequence numbers.
module difftest_commit_packer #(
    parameter int unsigned COMMIT_WIDTH = 2,
    parameter int unsigned DEPTH        = 8,
    parameter logic [7:0]  CORE_ID      = 8'd0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [COMMIT_WIDTH-1:0]    io_in_valid,
    input  logic [64*COMMIT_WIDTH-1:0] io_in_pc,
    input  logic [32*COMMIT_WIDTH-1:0] io_in_instr,
    input  logic [10*COMMIT_WIDTH-1:0] io_in_robIdx,
    input  logic [8*COMMIT_WIDTH-1:0]  io_in_wdest,
    input  logic [4*COMMIT_WIDTH-1:0]  io_in_flags,
    output logic                       io_out_valid,
    input  logic                       io_out_ready,
    output logic [63:0]                io_out_pc,
    output logic [31:0]                io_out_instr,
    output logic [9:0]                 io_out_robIdx,
    output logic [7:0]                 io_out_wdest,
    output logic [3:0]                 io_out_flags,
    output logic [7:0]                 io_out_index,
    output logic [7:0]                 io_out_coreid,
`ifdef DIFFTEST_COMMIT_SEQ_EN
    output logic [31:0]                io_out_seq,
`endif
    output logic                       io_overflow,
    output logic [15:0]                io_drop_cnt
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    logic [63:0] pc_q    [DEPTH];
    logic [31:0] instr_q [DEPTH];
    logic [9:0]  rob_q   [DEPTH];
    logic [7:0]  wdest_q [DEPTH];
    logic [3:0]  flags_q [DEPTH];
    logic [7:0]  index_q [DEPTH];

    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [15:0]     drop_cnt_q, drop_cnt_d;

    logic [CntW-1:0] n;
    logic [CntW-1:0] free;
    logic [CntW-1:0] lane_off  [COMMIT_WIDTH];
    logic [PtrW-1:0] lane_slot [COMMIT_WIDTH];
    logic            do_wr, do_drop, do_deq;
    logic [16:0]     drop_sum;

`ifdef DIFFTEST_COMMIT_SEQ_EN
    logic [31:0] seq_mem_q [DEPTH];
    logic [31:0] seq_q, seq_d;
`endif

    // Each valid lane lands at wr_ptr plus the number of valid lanes below it.
    always_comb begin
        n = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            lane_off[i]  = n;
            lane_slot[i] = PtrW'({1'b0, wr_ptr_q} + n);
            if (io_in_valid[i]) begin
                n = n + CntW'(1);
            end
        end
    end

    // Free space ignores a same-cycle dequeue; overflow drops the whole group.
    always_comb begin
        free       = CntW'(DEPTH) - count_q;
        do_wr      = enable && (n != '0) && (n <= free);
        do_drop    = enable && (n != '0) && (n > free);
        do_deq     = (count_q != '0) && io_out_ready;
        wr_ptr_d   = do_wr ? PtrW'({1'b0, wr_ptr_q} + n) : wr_ptr_q;
        rd_ptr_d   = do_deq ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d    = count_q + (do_wr ? n : '0) - CntW'(do_deq);
        overflow_d = overflow_q | do_drop;
        drop_sum   = {1'b0, drop_cnt_q} + 17'(n);
        drop_cnt_d = drop_cnt_q;
        if (do_drop) begin
            drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
`ifdef DIFFTEST_COMMIT_SEQ_EN
        seq_d = do_wr ? seq_q + 32'(n) : seq_q;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                pc_q[e]    <= '0;
                instr_q[e] <= '0;
                rob_q[e]   <= '0;
                wdest_q[e] <= '0;
                flags_q[e] <= '0;
                index_q[e] <= '0;
`ifdef DIFFTEST_COMMIT_SEQ_EN
                seq_mem_q[e] <= '0;
`endif
            end
`ifdef DIFFTEST_COMMIT_SEQ_EN
            seq_q <= '0;
`endif
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
`ifdef DIFFTEST_COMMIT_SEQ_EN
            seq_q <= seq_d;
`endif
            if (do_wr) begin
                for (int i = 0; i < COMMIT_WIDTH; i++) begin
                    if (io_in_valid[i]) begin
                        pc_q[lane_slot[i]]    <= io_in_pc[64*i +: 64];
                        instr_q[lane_slot[i]] <= io_in_instr[32*i +: 32];
                        rob_q[lane_slot[i]]   <= io_in_robIdx[10*i +: 10];
                        wdest_q[lane_slot[i]] <= io_in_wdest[8*i +: 8];
                        flags_q[lane_slot[i]] <= io_in_flags[4*i +: 4];
                        index_q[lane_slot[i]] <= 8'(i);
`ifdef DIFFTEST_COMMIT_SEQ_EN
                        seq_mem_q[lane_slot[i]] <= seq_q + 32'(lane_off[i]);
`endif
                    end
                end
            end
        end
    end

    always_comb begin
        io_out_valid  = (count_q != '0);
        io_out_pc     = pc_q[rd_ptr_q];
        io_out_instr  = instr_q[rd_ptr_q];
        io_out_robIdx = rob_q[rd_ptr_q];
        io_out_wdest  = wdest_q[rd_ptr_q];
        io_out_flags  = flags_q[rd_ptr_q];
        io_out_index  = index_q[rd_ptr_q];
        io_out_coreid = CORE_ID;
        io_overflow   = overflow_q;
        io_drop_cnt   = drop_cnt_q;
`ifdef DIFFTEST_COMMIT_SEQ_EN
        io_out_seq    = seq_mem_q[rd_ptr_q];
`endif
    end

endmodule
